// File: rtl/stage2_decode_skid_pkg.sv
// Shared CPU definitions: opcodes, the decoded instruction record and its immediate view.
package stage2_decode_skid_pkg;

    localparam int REGISTER_DEPTH = 32;
    localparam int ILEN           = 32;

    typedef enum logic [6:0] {
        OP_NONE   = 7'b0000000,
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111
    } opcode_e;

    typedef union packed {
        logic signed [ILEN-1:0] s;
        logic        [ILEN-1:0] u;
    } immediate_t;

    typedef struct packed {
        opcode_e    opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic [6:0] funct7;
        immediate_t imm;
    } decoded_instruction_t;

endpackage

// File: rtl/stage2_decode_skid_decoder.sv
// Combinational RV32 base decoder; fields a format does not use are left at zero.
module rv_decoder
    import stage2_decode_skid_pkg::*;
(
    input  logic [31:0]          i_instr,
    output decoded_instruction_t o_dec,
    output logic                 o_uses_rs1,
    output logic                 o_uses_rs2,
    output logic                 o_illegal
);

    always_comb begin
        o_dec      = '0;
        o_uses_rs1 = 1'b0;
        o_uses_rs2 = 1'b0;
        o_illegal  = 1'b0;
        case (i_instr[6:0])
            OP_LUI, OP_AUIPC: begin
                o_dec.opcode = opcode_e'(i_instr[6:0]);
                o_dec.rd     = i_instr[11:7];
                o_dec.imm.u  = {i_instr[31:12], 12'b0};
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                o_dec.opcode = opcode_e'(i_instr[6:0]);
                o_dec.rd     = i_instr[11:7];
                o_dec.rs1    = i_instr[19:15];
                o_dec.funct3 = i_instr[14:12];
                o_dec.imm.u  = {{20{i_instr[31]}}, i_instr[31:20]};
                o_uses_rs1   = 1'b1;
            end
            OP_REG: begin
                o_dec.opcode = OP_REG;
                o_dec.rd     = i_instr[11:7];
                o_dec.rs1    = i_instr[19:15];
                o_dec.rs2    = i_instr[24:20];
                o_dec.funct3 = i_instr[14:12];
                o_dec.funct7 = i_instr[31:25];
                o_uses_rs1   = 1'b1;
                o_uses_rs2   = 1'b1;
            end
            OP_STORE: begin
                o_dec.opcode = OP_STORE;
                o_dec.rs1    = i_instr[19:15];
                o_dec.rs2    = i_instr[24:20];
                o_dec.funct3 = i_instr[14:12];
                o_dec.imm.u  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
                o_uses_rs1   = 1'b1;
                o_uses_rs2   = 1'b1;
            end
            OP_BRANCH: begin
                o_dec.opcode = OP_BRANCH;
                o_dec.rs1    = i_instr[19:15];
                o_dec.rs2    = i_instr[24:20];
                o_dec.funct3 = i_instr[14:12];
                o_dec.imm.u  = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                i_instr[30:25], i_instr[11:8], 1'b0};
                o_uses_rs1   = 1'b1;
                o_uses_rs2   = 1'b1;
            end
            OP_JAL: begin
                o_dec.opcode = OP_JAL;
                o_dec.rd     = i_instr[11:7];
                o_dec.imm.u  = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                i_instr[20], i_instr[30:21], 1'b0};
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/stage2_decode_skid.sv
// Decode stage: register-file read with writeback bypass, load-use stall,
// and a one-entry skid buffer behind the output register.
module stage2_decode_skid
    import stage2_decode_skid_pkg::*;
#(
    parameter  int XLEN      = 32,
    parameter  int PC_WIDTH  = 32,
    parameter  int REG_COUNT = REGISTER_DEPTH,
    localparam int RA_W      = $clog2(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PC_WIDTH-1:0]  in_pc,
    input  logic [31:0]          in_instr,
    input  logic                 in_pred,
    output logic                 rf_en,
    output logic [RA_W-1:0]      rf_addr1,
    output logic [RA_W-1:0]      rf_addr2,
    input  logic [XLEN-1:0]      rf_data1,
    input  logic [XLEN-1:0]      rf_data2,
    input  logic                 wb_valid,
    input  logic [RA_W-1:0]      wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 ex_load_valid,
    input  logic [RA_W-1:0]      ex_load_rd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PC_WIDTH-1:0]  out_pc,
    output logic                 out_pred,
    output decoded_instruction_t out_instr,
    output logic [XLEN-1:0]      out_rs1_val,
    output logic [XLEN-1:0]      out_rs2_val,
    output logic                 out_illegal
);

    // Operand for a newly decoded instruction: x0 reads zero, writeback wins over the RF.
    function automatic logic [XLEN-1:0] sel_operand(input logic [RA_W-1:0] rs,
                                                    input logic [XLEN-1:0] rf,
                                                    input logic            wbv,
                                                    input logic [RA_W-1:0] wbrd,
                                                    input logic [XLEN-1:0] wbd);
        if (rs == '0)                return '0;
        else if (wbv && wbrd == rs)  return wbd;
        else                         return rf;
    endfunction

    // Operand for an entry already held: refreshed by any matching writeback.
    function automatic logic [XLEN-1:0] held_operand(input logic [RA_W-1:0] rs,
                                                     input logic [XLEN-1:0] cur,
                                                     input logic            wbv,
                                                     input logic [RA_W-1:0] wbrd,
                                                     input logic [XLEN-1:0] wbd);
        if (rs != '0 && wbv && wbrd == rs) return wbd;
        else                               return cur;
    endfunction

    decoded_instruction_t w_dec;
    logic                 w_uses_rs1, w_uses_rs2, w_illegal;
    logic [RA_W-1:0]      w_rs1, w_rs2;
    logic [XLEN-1:0]      w_rs1_val, w_rs2_val;
    logic                 w_hazard, w_accept, w_out_free;
    logic                 w_load_from_skid, w_load_from_in, w_skid_load;

    logic                 r_out_valid, r_out_illegal, r_out_pred;
    logic [PC_WIDTH-1:0]  r_out_pc;
    decoded_instruction_t r_out_instr;
    logic [XLEN-1:0]      r_out_rs1_val, r_out_rs2_val;

    logic                 r_skid_valid, r_skid_illegal, r_skid_pred;
    logic [PC_WIDTH-1:0]  r_skid_pc;
    decoded_instruction_t r_skid_instr;
    logic [XLEN-1:0]      r_skid_rs1_val, r_skid_rs2_val;

    rv_decoder u_dec (
        .i_instr    (in_instr),
        .o_dec      (w_dec),
        .o_uses_rs1 (w_uses_rs1),
        .o_uses_rs2 (w_uses_rs2),
        .o_illegal  (w_illegal)
    );

    // Decoder zeroes unused register fields, so unused read ports address x0.
    assign w_rs1     = RA_W'(w_dec.rs1);
    assign w_rs2     = RA_W'(w_dec.rs2);
    assign rf_addr1  = w_rs1;
    assign rf_addr2  = w_rs2;
    assign rf_en     = w_uses_rs1 | w_uses_rs2;
    assign w_rs1_val = sel_operand(w_rs1, rf_data1, wb_valid, wb_rd, wb_data);
    assign w_rs2_val = sel_operand(w_rs2, rf_data2, wb_valid, wb_rd, wb_data);

    assign w_hazard = ex_load_valid && (ex_load_rd != '0) &&
                      ((w_uses_rs1 && ex_load_rd == w_rs1) ||
                       (w_uses_rs2 && ex_load_rd == w_rs2));
    assign in_ready = !r_skid_valid && !w_hazard;
    assign w_accept = in_valid && in_ready && !flush;

    // The skid entry is always older than the input, so it drains first.
    assign w_out_free       = !r_out_valid || out_ready;
    assign w_load_from_skid = w_out_free && r_skid_valid;
    assign w_load_from_in   = w_out_free && !r_skid_valid && w_accept;
    assign w_skid_load      = !w_out_free && w_accept;

    // ---- control registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid   <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_out_illegal <= 1'b0;
        end else begin
            if (flush) begin
                r_out_valid  <= 1'b0;
                r_skid_valid <= 1'b0;
            end else begin
                if (w_out_free)
                    r_out_valid <= r_skid_valid || w_accept;
                if (w_load_from_skid)
                    r_skid_valid <= 1'b0;
                else if (w_skid_load)
                    r_skid_valid <= 1'b1;
            end
            if (w_load_from_skid)
                r_out_illegal <= r_skid_illegal;
            else if (w_load_from_in)
                r_out_illegal <= w_illegal;
        end
    end

    // ---- data registers ----
    always_ff @(posedge clk) begin
        if (w_load_from_skid) begin
            r_out_pc      <= r_skid_pc;
            r_out_pred    <= r_skid_pred;
            r_out_instr   <= r_skid_instr;
            r_out_rs1_val <= held_operand(RA_W'(r_skid_instr.rs1), r_skid_rs1_val,
                                          wb_valid, wb_rd, wb_data);
            r_out_rs2_val <= held_operand(RA_W'(r_skid_instr.rs2), r_skid_rs2_val,
                                          wb_valid, wb_rd, wb_data);
        end else if (w_load_from_in) begin
            r_out_pc      <= in_pc;
            r_out_pred    <= in_pred;
            r_out_instr   <= w_dec;
            r_out_rs1_val <= w_rs1_val;
            r_out_rs2_val <= w_rs2_val;
        end else begin
            r_out_rs1_val <= held_operand(RA_W'(r_out_instr.rs1), r_out_rs1_val,
                                          wb_valid, wb_rd, wb_data);
            r_out_rs2_val <= held_operand(RA_W'(r_out_instr.rs2), r_out_rs2_val,
                                          wb_valid, wb_rd, wb_data);
        end

        if (w_skid_load) begin
            r_skid_pc      <= in_pc;
            r_skid_pred    <= in_pred;
            r_skid_instr   <= w_dec;
            r_skid_illegal <= w_illegal;
            r_skid_rs1_val <= w_rs1_val;
            r_skid_rs2_val <= w_rs2_val;
        end else begin
            r_skid_rs1_val <= held_operand(RA_W'(r_skid_instr.rs1), r_skid_rs1_val,
                                           wb_valid, wb_rd, wb_data);
            r_skid_rs2_val <= held_operand(RA_W'(r_skid_instr.rs2), r_skid_rs2_val,
                                           wb_valid, wb_rd, wb_data);
        end
    end

    assign out_valid   = r_out_valid;
    assign out_pc      = r_out_pc;
    assign out_pred    = r_out_pred;
    assign out_instr   = r_out_instr;
    assign out_rs1_val = r_out_rs1_val;
    assign out_rs2_val = r_out_rs2_val;
    assign out_illegal = r_out_illegal;

endmodule

// File: tb/tb_stage2_decode_skid.sv
// Scoreboard bench for stage2_decode_skid: directed instructions, expected results queued at issue.
module tb_stage2_decode_skid;
    import stage2_decode_skid_pkg::*;

    localparam logic [31:0] I_ADDI  = 32'hFFB10093; // addi x1,x2,-5
    localparam logic [31:0] I_ADDI0 = 32'h00500093; // addi x1,x0,5
    localparam logic [31:0] I_ADD   = 32'h006281B3; // add  x3,x5,x6
    localparam logic [31:0] I_ADD4  = 32'h004083B3; // add  x7,x1,x4
    localparam logic [31:0] I_LUI   = 32'h123452B7; // lui  x5,0x12345
    localparam logic [31:0] I_JAL   = 32'hFFDFF0EF; // jal  x1,-4
    localparam logic [31:0] I_BEQ   = 32'h00208463; // beq  x1,x2,+8
    localparam logic [31:0] I_SW    = 32'hFE62AC23; // sw   x6,-8(x5)
    localparam logic [31:0] I_BAD   = 32'h0000007F;

    logic clk = 1'b0;
    logic rst, flush, in_valid, in_ready, in_pred, rf_en;
    logic [31:0] in_pc, in_instr, rf_data1, rf_data2, wb_data;
    logic [4:0]  rf_addr1, rf_addr2, wb_rd, ex_load_rd;
    logic wb_valid, ex_load_valid, out_valid, out_ready, out_pred, out_illegal;
    logic [31:0] out_pc, out_rs1_val, out_rs2_val;
    decoded_instruction_t out_instr;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] v1;
        logic [31:0] v2;
        logic        ill;
        logic        pred;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    stage2_decode_skid dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_pred(in_pred),
        .rf_en(rf_en), .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_pred(out_pred), .out_instr(out_instr),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_illegal(out_illegal)
    );

    // Register file contents: x2 holds 7, every other xN holds 0x1000+N.
    function automatic logic [31:0] rfv(input logic [4:0] a);
        return (a == 5'd2) ? 32'd7 : (32'h1000 + {27'b0, a});
    endfunction
    assign rf_data1 = rfv(rf_addr1);
    assign rf_data2 = rfv(rf_addr2);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic pred);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
        in_pred  = pred;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] v1,
                        input logic [31:0] v2, input logic ill, input logic pred);
        exp_t e;
        e.pc = pc; e.imm = imm; e.v1 = v1; e.v2 = v2; e.ill = ill; e.pred = pred;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out: got pc %h, required no output", out_pc);
            end else begin
                m_e = sb.pop_front();
                if (out_pc !== m_e.pc || out_instr.imm.u !== m_e.imm ||
                    out_rs1_val !== m_e.v1 || out_rs2_val !== m_e.v2 ||
                    out_illegal !== m_e.ill || out_pred !== m_e.pred) begin
                    n_fail++;
                    $display("FAIL out_txn: got pc=%h imm=%h rs1=%h rs2=%h ill=%b pred=%b, required pc=%h imm=%h rs1=%h rs2=%h ill=%b pred=%b",
                             out_pc, out_instr.imm.u, out_rs1_val, out_rs2_val, out_illegal, out_pred,
                             m_e.pc, m_e.imm, m_e.v1, m_e.v2, m_e.ill, m_e.pred);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; in_pred = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0; ex_load_valid = 1'b0; ex_load_rd = '0;
        out_ready = 1'b1;
        tick(); tick();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_illegal", {31'b0, out_illegal}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        rst = 1'b0;
        tick();

        // ADDI with latency-1 presentation
        drive(32'h100, I_ADDI, 1'b0);
        push(32'h100, 32'hFFFFFFFB, 32'd7, 32'd0, 1'b0, 1'b0);
        #1;
        chk("addi_rf_en", {31'b0, rf_en}, 32'd1);
        chk("addi_rf_addr1", {27'b0, rf_addr1}, 32'd2);
        chk("addi_rf_addr2", {27'b0, rf_addr2}, 32'd0);
        tick();
        in_valid = 1'b0;
        chk("addi_out_valid", {31'b0, out_valid}, 32'd1);
        chk("addi_imm", out_instr.imm.u, 32'hFFFFFFFB);
        tick();
        chk("addi_drained", {31'b0, out_valid}, 32'd0);

        // Back-to-back stream of formats, with input-side bypass cases
        drive(32'h110, I_LUI, 1'b0);
        push(32'h110, 32'h12345000, 32'd0, 32'd0, 1'b0, 1'b0);
        #1;
        chk("lui_rf_en", {31'b0, rf_en}, 32'd0);
        tick();
        drive(32'h114, I_JAL, 1'b1);
        push(32'h114, 32'hFFFFFFFC, 32'd0, 32'd0, 1'b0, 1'b1);
        tick();
        drive(32'h118, I_BEQ, 1'b1);
        push(32'h118, 32'd8, 32'h1001, 32'd7, 1'b0, 1'b1);
        tick();
        drive(32'h11C, I_SW, 1'b0);
        push(32'h11C, 32'hFFFFFFF8, 32'h1005, 32'h1006, 1'b0, 1'b0);
        #1;
        chk("sw_rf_addr2", {27'b0, rf_addr2}, 32'd6);
        tick();
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h99;
        drive(32'h120, I_ADDI0, 1'b0);
        push(32'h120, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        wb_rd = 5'd2; wb_data = 32'h55;
        drive(32'h124, I_ADDI, 1'b0);
        push(32'h124, 32'hFFFFFFFB, 32'h55, 32'd0, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0; wb_valid = 1'b0;
        tick(); tick();

        // Skid: output stalled for three cycles with input held valid
        out_ready = 1'b0;
        drive(32'h200, I_ADD, 1'b0);
        push(32'h200, 32'd0, 32'h1005, 32'h1006, 1'b0, 1'b0);
        #1;
        chk("skid_c0_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        drive(32'h204, I_SW, 1'b0);
        push(32'h204, 32'hFFFFFFF8, 32'h1005, 32'h1006, 1'b0, 1'b0);
        #1;
        chk("skid_c1_in_ready", {31'b0, in_ready}, 32'd1);
        chk("skid_c1_out_valid", {31'b0, out_valid}, 32'd1);
        tick();
        drive(32'h208, I_BEQ, 1'b1);
        #1;
        chk("skid_c2_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        chk("skid_c3_in_ready", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        tick();
        chk("skid_release_in_ready", {31'b0, in_ready}, 32'd1);
        push(32'h208, 32'd8, 32'h1001, 32'd7, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("skid_third_out_valid", {31'b0, out_valid}, 32'd1);
        tick();
        chk("skid_empty_after", {31'b0, out_valid}, 32'd0);
        tick();

        // Load-use hazard: bubble, then accept once the load clears
        drive(32'h400, I_LUI, 1'b0);
        push(32'h400, 32'h12345000, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        drive(32'h404, I_ADD, 1'b0);
        ex_load_valid = 1'b1; ex_load_rd = 5'd5;
        #1;
        chk("hazard_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        chk("hazard_bubble", {31'b0, out_valid}, 32'd0);
        ex_load_valid = 1'b0;
        #1;
        chk("hazard_clear_in_ready", {31'b0, in_ready}, 32'd1);
        push(32'h404, 32'd0, 32'h1005, 32'h1006, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("hazard_accepted", {31'b0, out_valid}, 32'd1);
        tick(); tick();

        // Writeback refreshes a held operand; x0 writeback leaves it alone
        out_ready = 1'b0;
        drive(32'h500, I_ADD4, 1'b0);
        push(32'h500, 32'd0, 32'h1001, 32'h1234, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h1234;
        tick();
        wb_rd = 5'd0; wb_data = 32'hBAD;
        tick();
        wb_valid = 1'b0;
        chk("held_rs2_bypass", out_rs2_val, 32'h1234);
        out_ready = 1'b1;
        tick(); tick();

        // Flush with output and skid both occupied
        out_ready = 1'b0;
        drive(32'h600, I_LUI, 1'b0);
        tick();
        drive(32'h604, I_JAL, 1'b1);
        tick();
        chk("flush_pre_in_ready", {31'b0, in_ready}, 32'd0);
        drive(32'h608, I_ADDI, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        tick();
        chk("flush_dropped_input", {31'b0, out_valid}, 32'd0);

        // Illegal opcode
        drive(32'h700, I_BAD, 1'b0);
        push(32'h700, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        #1;
        chk("illegal_rf_en", {31'b0, rf_en}, 32'd0);
        tick();
        in_valid = 1'b0;
        chk("illegal_flag", {31'b0, out_illegal}, 32'd1);
        tick(); tick();

        // Reset while stalled drops everything held
        out_ready = 1'b0;
        drive(32'h800, I_LUI, 1'b0);
        tick();
        drive(32'h804, I_JAL, 1'b0);
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_stall_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_stall_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        tick();
        chk("rst_stall_no_output", {31'b0, out_valid}, 32'd0);
        tick();

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
